// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Rounded clk cycles per bit.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with push/pop, full/empty flags and an occupancy level.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop)
            level_d = level_q + 1'b1;
        else if (do_pop && !do_push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_buffered_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          rs232_tx
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(UART_DATA_BITS);

    tx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      bit_tick;
    logic                      load;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_rd;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_valid & tx_ready),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tx_ready = ~fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign rs232_tx = tx_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        load     = 1'b0;
        bit_tick = (cnt_q == CW'(DIV - 1));
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        if (state_q != IDLE)
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty)
                    load = 1'b1;
            end
            START: begin
                tx_d = 1'b0;
                if (bit_tick)
                    state_d = DATA;
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(UART_DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (bit_tick)
                    state_d = STOP;
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                // Chain straight into the next start bit when data is waiting.
                if (bit_tick) begin
                    if (!fifo_empty)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = fifo_rd;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_rd;
`endif
        end
        fifo_pop = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Directed bench for uart_buffered_tx at DIV=10; a line monitor decodes frames into queues.
module tb_uart_buffered_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 110;
`else
    localparam int FRAME = 100;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [4:0] fifo_level;
    logic       busy;
    logic       rs232_tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b1;

    logic [7:0] mon_byte [$];
    int         mon_start[$];
    logic       mon_ok   [$];
    logic       mon_par  [$];

    uart_buffered_tx #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .rs232_tx   (rs232_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && mon_byte.size() < n; i++)
            step(1);
        chk("frame_count", mon_byte.size(), n);
    endtask

    task automatic clear_mon();
        mon_byte.delete();
        mon_start.delete();
        mon_ok.delete();
        mon_par.delete();
    endtask

    // Mid-bit sampling line decoder.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n && rs232_tx === 1'b0) begin
                int         s;
                logic [7:0] b;
                logic       ok;
                logic       p;
                s  = cyc;
                p  = 1'b0;
                step(5);
                ok = (rs232_tx === 1'b0);
                for (int k = 0; k < 8; k++) begin
                    step(10);
                    b[k] = rs232_tx;
                end
`ifdef UART_TX_PARITY_EN
                step(10);
                p = rs232_tx;
`endif
                step(10);
                ok = ok && (rs232_tx === 1'b1);
                mon_byte.push_back(b);
                mon_start.push_back(s);
                mon_ok.push_back(ok);
                mon_par.push_back(p);
            end
        end
    end

    initial begin
        int p0, a, acc, nxt, lows, busys, n0;
        logic rdy_prev;

        // Reset state
        step(3);
        chk("rst_tx", rs232_tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step(3);
        chk("idle_tx", rs232_tx, 1'b1);

        // 1: single byte 0x55, latency and busy window
        clear_mon();
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        step(1);
        p0 = cyc;
        tx_valid = 1'b0;
        chk("t1_level_push", fifo_level, 5'd1);
        chk("t1_busy_push", busy, 1'b1);
        chk("t1_tx_n1", rs232_tx, 1'b1);
        step(1);
        chk("t1_tx_n2", rs232_tx, 1'b1);
        chk("t1_level_pop", fifo_level, 5'd0);
        step(1);
        chk("t1_tx_fall", rs232_tx, 1'b0);
        wait_frames(1, 200);
        if (mon_byte.size() >= 1) begin
            chk("t1_byte", mon_byte[0], 8'h55);
            chk("t1_framing", mon_ok[0], 1'b1);
            chk("t1_start_cyc", mon_start[0], p0 + 2);
        end
        while (cyc < p0 + FRAME)
            step(1);
        chk("t1_busy_last", busy, 1'b1);
        step(1);
        chk("t1_busy_drop", busy, 1'b0);
        step(20);

        // 2: two bytes back-to-back
        clear_mon();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        step(1);
        tx_data  = 8'h3C;
        step(1);
        tx_valid = 1'b0;
        wait_frames(2, 2 * FRAME + 100);
        if (mon_byte.size() >= 2) begin
            chk("t2_byte0", mon_byte[0], 8'hA5);
            chk("t2_byte1", mon_byte[1], 8'h3C);
            chk("t2_framing0", mon_ok[0], 1'b1);
            chk("t2_framing1", mon_ok[1], 1'b1);
            chk("t2_no_gap", mon_start[1] - mon_start[0], FRAME);
        end
        step(30);

        // 3: continuous producer, fill to full and refill
        clear_mon();
        acc = 0;
        nxt = 0;
        a   = 0;
        tx_valid = 1'b1;
        tx_data  = 8'd0;
        rdy_prev = tx_ready;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (rdy_prev) begin
                acc++;
                if (acc == 1)
                    a = cyc;
                nxt++;
                tx_data = 8'(nxt);
            end
            rdy_prev = tx_ready;
            if (!tx_ready)
                break;
        end
        chk("t3_accepted", acc, 17);
        chk("t3_level_full", fifo_level, 5'd16);
        chk("t3_ready_low", tx_ready, 1'b0);
        for (int i = 0; i < 2 * FRAME && !tx_ready; i++)
            step(1);
        chk("t3_ready_cyc", cyc, a + 1 + FRAME);
        step(1);
        tx_valid = 1'b0;
        chk("t3_refill_level", fifo_level, 5'd16);
        wait_frames(18, 19 * FRAME + 200);
        if (mon_byte.size() >= 18) begin
            for (int i = 0; i < 18; i++)
                chk($sformatf("t3_byte%0d", i), mon_byte[i], 8'(i));
            chk("t3_span", mon_start[17] - mon_start[0], 17 * FRAME);
        end
        step(30);

        // 4: reset mid-frame with bytes queued
        mon_en = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        step(1);
        n0 = cyc;
        for (int i = 1; i < 5; i++) begin
            tx_data = 8'hF0 + 8'(i);
            step(1);
        end
        tx_valid = 1'b0;
        chk("t4_level_q", fifo_level, 5'd4);
        while (cyc < n0 + 45)
            step(1);
        chk("t4_bit3_low", rs232_tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_tx_async", rs232_tx, 1'b1);
        chk("t4_level", fifo_level, 5'd0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_ready", tx_ready, 1'b1);
        step(2);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (rs232_tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        chk("t4_no_resume_tx", lows, 0);
        chk("t4_no_resume_busy", busys, 0);
        clear_mon();
        mon_en = 1'b1;

        // 5: parity / frame length
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        step(1);
        tx_data  = 8'h03;
        step(1);
        tx_valid = 1'b0;
        wait_frames(2, 2 * FRAME + 100);
        if (mon_byte.size() >= 2) begin
            chk("t5_byte0", mon_byte[0], 8'h07);
            chk("t5_byte1", mon_byte[1], 8'h03);
            chk("t5_framing0", mon_ok[0], 1'b1);
            chk("t5_framing1", mon_ok[1], 1'b1);
            chk("t5_frame_len", mon_start[1] - mon_start[0], FRAME);
`ifdef UART_TX_PARITY_EN
            chk("t5_par0", mon_par[0], 1'b1);
            chk("t5_par1", mon_par[1], 1'b0);
`endif
        end
        step(30);
        chk("end_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
